// File: rtl/mips_pkg.sv
// Shared constants for the mini MIPS datapath: word width and the
// two-entry elastic stage state encoding.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    // State encoding doubles as the held-word count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        StEmpty = ST_EMPTY,
        StOne   = ST_ONE,
        StFull  = ST_FULL
    } state_t;

endpackage

// File: rtl/pipe_skid32.sv
// Two-entry elastic pipeline register with skid buffer and synchronous flush.
// All outputs decode registers only, so in_ready never depends on out_ready
// within a cycle.
module pipe_skid32
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state and data-register steering; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Data registers keep stale contents; out_valid=0 masks them.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        // Zero-bubble pass-through.
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = StFull;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        state_d = StOne;
                        main_d  = skid_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State and data registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Output decode of registered state.
    always_comb begin
        out_data  = main_q;
        out_valid = (state_q != StEmpty);
        in_ready  = (state_q != StFull);
        occupancy = state_q;
    end

endmodule

// File: tb/tb_pipe_skid32.sv
// Self-checking bench for pipe_skid32 against a queue-based model of a
// two-deep in-order buffer.
module tb_pipe_skid32;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [1:0]  occupancy;

    int          errs;
    int          checks;
    logic [31:0] model_q[$];

    pipe_skid32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and update the model: at most two words held,
    // oldest leaves first, flush or reset empties everything.
    task automatic tick();
        bit          fi;
        bit          fo;
        logic [31:0] d;
        fi = in_valid && (model_q.size() < 2);
        fo = out_ready && (model_q.size() > 0);
        d  = in_data;
        @(posedge clk);
        #1;
        if (!rst_n || flush) begin
            model_q.delete();
        end else begin
            if (fo) void'(model_q.pop_front());
            if (fi) model_q.push_back(d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b0;
        #3;
        tick();
        tick();
        checks += 4;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        if (occupancy !== 2'd0) begin errs++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        if (out_data !== 32'h0) begin errs++; $display("FAIL reset_data: got %h want 0", out_data); end
        rst_n = 1'b1;
        in_data = 32'h0000_0001;
        tick();
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin errs++; $display("FAIL first_valid: got %b want 1", out_valid); end
        if (out_data !== 32'h0000_0001) begin errs++; $display("FAIL first_data: got %h want 00000001", out_data); end
        if (occupancy !== 2'd1) begin errs++; $display("FAIL first_occ: got %0d want 1", occupancy); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL drain_valid: got %b want 0", out_valid); end
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA000_0000 + 32'(i);
            checks++;
            if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            checks += 3;
            if (out_valid !== 1'b1) begin errs++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
            if (out_data !== 32'hA000_0000 + 32'(i)) begin
                errs++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, 32'hA000_0000 + 32'(i));
            end
            if (occupancy !== 2'd1) begin errs++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (occupancy !== 2'd0) begin errs++; $display("FAIL stream_end_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1111_1111;
        tick();
        in_data = 32'h2222_2222;
        tick();
        checks += 3;
        if (occupancy !== 2'd2) begin errs++; $display("FAIL bp_occ: got %0d want 2", occupancy); end
        if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready: got %b want 0", in_ready); end
        if (out_data !== 32'h1111_1111) begin errs++; $display("FAIL bp_data: got %h want 11111111", out_data); end
        in_data = 32'h3333_3333;
        tick();
        tick();
        checks += 2;
        if (occupancy !== 2'd2) begin errs++; $display("FAIL bp_hold_occ: got %0d want 2", occupancy); end
        if (out_data !== 32'h1111_1111) begin errs++; $display("FAIL bp_hold_data: got %h want 11111111", out_data); end
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (out_data !== 32'h2222_2222) begin errs++; $display("FAIL bp_out2: got %h want 22222222", out_data); end
        if (occupancy !== 2'd1) begin errs++; $display("FAIL bp_out2_occ: got %0d want 1", occupancy); end
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (out_data !== 32'h3333_3333) begin errs++; $display("FAIL bp_out3: got %h want 33333333", out_data); end
        if (occupancy !== 2'd1) begin errs++; $display("FAIL bp_out3_occ: got %0d want 1", occupancy); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5555_0001;
        tick();
        in_data = 32'h5555_0002;
        tick();
        checks++;
        if (occupancy !== 2'd2) begin errs++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
        flush   = 1'b1;
        in_data = 32'hDEAD_BEEF;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks += 3;
        if (occupancy !== 2'd0) begin errs++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_leak[%0d]: got valid %b data %h", i, out_valid, out_data); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h7777_0001;
        tick();
        in_data = 32'h7777_0002;
        tick();
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd2) begin errs++; $display("FAIL arst_pre_occ: got %0d want 2", occupancy); end
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        checks += 3;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        if (occupancy !== 2'd0) begin errs++; $display("FAIL arst_occ: got %0d want 0", occupancy); end
        if (out_data !== 32'h0) begin errs++; $display("FAIL arst_data: got %h want 0", out_data); end
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h8888_0001;
        tick();
        in_valid = 1'b0;
        checks += 2;
        if (out_data !== 32'h8888_0001) begin errs++; $display("FAIL arst_resume_data: got %h want 88880001", out_data); end
        if (occupancy !== 2'd1) begin errs++; $display("FAIL arst_resume_occ: got %0d want 1", occupancy); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        bit          stall;
        logic [31:0] prev;
        int          sz;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 99) == 0);
            stall     = (model_q.size() > 0) && !out_ready && !flush;
            prev      = out_data;
            tick();
            sz = model_q.size();
            checks += 3;
            if (out_valid !== (sz > 0)) begin errs++; $display("FAIL rnd_valid@%0d: got %b want %b", c, out_valid, sz > 0); end
            if (in_ready !== (sz < 2)) begin errs++; $display("FAIL rnd_ready@%0d: got %b want %b", c, in_ready, sz < 2); end
            if (occupancy !== 2'(sz)) begin errs++; $display("FAIL rnd_occ@%0d: got %0d want %0d", c, occupancy, sz); end
            if (sz > 0) begin
                checks++;
                if (out_data !== model_q[0]) begin errs++; $display("FAIL rnd_data@%0d: got %h want %h", c, out_data, model_q[0]); end
            end
            if (stall) begin
                checks++;
                if (out_data !== prev) begin errs++; $display("FAIL rnd_stable@%0d: got %h want %h", c, out_data, prev); end
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
